// File: rtl/seq_pkg.sv
// Shared sequence-generator types and defaults.
// Reused by the 10010 generator and future sequence detectors.
package seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int         PAT_W_DEF = 5;
  localparam logic [4:0] PAT_DEF   = 5'b10010;

  localparam int IDX_W = 3;
  localparam int CNT_W = 4;

endpackage

// File: rtl/seq_gen_10010_if.sv
// Request/serial-output bundle of the 10010 sequence generator.
// master drives requests, slave returns the serial stream.
interface seq_gen_10010_if;
  import seq_pkg::*;

  logic             start;
  logic [CNT_W-1:0] rep_cnt;
  logic             dout;
  logic             dout_vld;
  logic             busy;
  logic             done;

  modport master (
    output start, rep_cnt,
    input  dout, dout_vld, busy, done
  );

  modport slave (
    input  start, rep_cnt,
    output dout, dout_vld, busy, done
  );

endinterface

// File: rtl/seq_gen_10010.sv
// Serial 10010 burst generator, all outputs registered.
// SEQ_GEN_OVERLAP_EN: frames 2..N reuse the trailing OVL_KEEP bits.
module seq_gen_10010
  import seq_pkg::*;
#(
  parameter int             PAT_W    = PAT_W_DEF,
  parameter logic [PAT_W-1:0] PAT    = PAT_DEF,
  parameter int             OVL_KEEP = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] rep_cnt,
  output logic             dout,
  output logic             dout_vld,
  output logic             busy,
  output logic             done
);

`ifdef SEQ_GEN_OVERLAP_EN
  localparam int KEEP = OVL_KEEP;
`else
  localparam int KEEP = OVL_KEEP * 0;
`endif

  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(PAT_W - 1);
  localparam logic [IDX_W-1:0] IDX_RLD = IDX_W'(PAT_W - 1 - KEEP);
  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] frm_q, frm_d;
  logic [CNT_W-1:0] rep_q, rep_d;
  logic             dout_q, dout_d;
  logic             vld_q, vld_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Next state, counters and the registered output values.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    frm_d   = frm_q;
    rep_d   = rep_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SEND;
          idx_d   = IDX_TOP;
          frm_d   = rep_cnt;
          rep_d   = rep_cnt;
        end
      end
      SEND: begin
        if (idx_q != '0) begin
          idx_d = idx_q - IDX_ONE;
        end else if (frm_q != '0) begin
          frm_d = frm_q - CNT_ONE;
          idx_d = IDX_RLD;
        end else begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    vld_d  = (state_d == SEND);
    busy_d = (state_d == SEND);
    done_d = (state_d == DONE);
    dout_d = (state_d == SEND) && PAT[idx_d];
  end

  // State, counters and outputs with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      frm_q   <= '0;
      rep_q   <= '0;
      dout_q  <= 1'b0;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      frm_q   <= frm_d;
      rep_q   <= rep_d;
      dout_q  <= dout_d;
      vld_q   <= vld_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Remaining frames never exceed the latched burst length.
  a_frm_le_rep: assert property (
    @(posedge clk) disable iff (!rst)
    (state_q == SEND) |-> (frm_q <= rep_q)
  );

  assign dout     = dout_q;
  assign dout_vld = vld_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_seq_gen_10010.sv
// Self-checking bench for seq_gen_10010 with a stream-level model.
// Builds in both default and SEQ_GEN_OVERLAP_EN configurations.
module tb_seq_gen_10010;

  localparam int         PW   = 5;
  localparam logic [4:0] PAT  = 5'b10010;
  localparam int         KEEP = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;

  seq_gen_10010_if bus ();

  always #5 clk = ~clk;

  seq_gen_10010 dut (
    .clk      (clk),
    .rst      (rst),
    .start    (bus.start),
    .rep_cnt  (bus.rep_cnt),
    .dout     (bus.dout),
    .dout_vld (bus.dout_vld),
    .busy     (bus.busy),
    .done     (bus.done)
  );

  int checks = 0;
  int errors = 0;
  bit exp_q[$];
  bit got_q[$];
  int done_cnt;

  function automatic logic [3:0] outs();
    return {bus.dout, bus.dout_vld, bus.busy, bus.done};
  endfunction

  task automatic build_exp(input int rep);
    int top;
`ifdef SEQ_GEN_OVERLAP_EN
    top = PW - 1 - KEEP;
`else
    top = PW - 1;
`endif
    exp_q.delete();
    for (int i = PW - 1; i >= 0; i--) exp_q.push_back(PAT[i]);
    for (int f = 1; f <= rep; f++)
      for (int i = top; i >= 0; i--) exp_q.push_back(PAT[i]);
  endtask

  function automatic int first_diff();
    int n;
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      if (got_q[i] != exp_q[i]) return i;
    if (got_q.size() != exp_q.size()) return n;
    return -1;
  endfunction

  function automatic int count_10010();
    int c;
    c = 0;
    for (int i = 0; i + PW <= got_q.size(); i++) begin
      bit hit;
      hit = 1'b1;
      for (int j = 0; j < PW; j++)
        if (got_q[i+j] != PAT[PW-1-j]) hit = 1'b0;
      if (hit) c++;
    end
    return c;
  endfunction

  task automatic run_burst(input int rep, input int chg_at, input int new_rep);
    int n;
    bit fin;
    got_q.delete();
    done_cnt = 0;
    n = 0;
    fin = 1'b0;
    @(negedge clk);
    bus.start   = 1'b1;
    bus.rep_cnt = rep[3:0];
    @(negedge clk);
    bus.start = 1'b0;
    while (!fin && n < 400) begin
      if (bus.dout_vld === 1'b1) got_q.push_back(bus.dout);
      checks++;
      if (bus.busy !== bus.dout_vld ||
          (bus.dout_vld !== 1'b1 && bus.dout !== 1'b0)) begin
        errors++;
        $display("FAIL burst_flags: got %b want busy==vld, dout=0 idle",
                 outs());
      end
      if (bus.done === 1'b1) begin
        done_cnt++;
        fin = 1'b1;
      end
      if (n == chg_at) bus.rep_cnt = new_rep[3:0];
      @(negedge clk);
      n++;
    end
    checks++;
    if (!fin) begin
      errors++;
      $display("FAIL burst_timeout: got no done after %0d cycles, want done",
               n);
    end
    checks++;
    if (outs() !== 4'b0000) begin
      errors++;
      $display("FAIL after_done: got %b want 0000", outs());
    end
  endtask

  task automatic test_reset();
    bus.start   = 1'b0;
    bus.rep_cnt = 4'd0;
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      bus.start = 1'b1;
      checks++;
      if (outs() !== 4'b0000) begin
        errors++;
        $display("FAIL reset_outs: got %b want 0000", outs());
      end
    end
    bus.start = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (outs() !== 4'b0000) begin
      errors++;
      $display("FAIL reset_release: got %b want 0000", outs());
    end
  endtask

  task automatic test_single();
    logic [3:0] exp;
    @(negedge clk);
    bus.start   = 1'b1;
    bus.rep_cnt = 4'd0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (k <= 5) exp = {PAT[5-k], 3'b110};
      else if (k == 6) exp = 4'b0001;
      else exp = 4'b0000;
      checks++;
      if (outs() !== exp) begin
        errors++;
        $display("FAIL single_t%0d: got %b want %b", k, outs(), exp);
      end
    end
  endtask

  task automatic test_rep2();
    build_exp(2);
    run_burst(2, -1, 0);
    checks++;
    if (first_diff() !== -1) begin
      errors++;
      $display("FAIL rep2_stream: got %0d bits want %0d, diff at %0d",
               got_q.size(), exp_q.size(), first_diff());
    end
    checks++;
    if (done_cnt !== 1) begin
      errors++;
      $display("FAIL rep2_done: got %0d want 1", done_cnt);
    end
    checks++;
    if (count_10010() !== 3) begin
      errors++;
      $display("FAIL rep2_matcher: got %0d want 3", count_10010());
    end
  endtask

  task automatic test_back_to_back();
    int w;
    logic [3:0] exp;
    int p;
    w = 0;
    @(negedge clk);
    bus.start   = 1'b1;
    bus.rep_cnt = 4'd0;
    @(negedge clk);
    while (bus.dout_vld !== 1'b1 && w < 10) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (w >= 10) begin
      errors++;
      $display("FAIL b2b_start: got no valid bit want one");
    end
    for (int i = 0; i < 21; i++) begin
      p = i % 7;
      if (p < 5) exp = {PAT[4-p], 3'b110};
      else if (p == 5) exp = 4'b0001;
      else exp = 4'b0000;
      checks++;
      if (outs() !== exp) begin
        errors++;
        $display("FAIL b2b_c%0d: got %b want %b", i, outs(), exp);
      end
      if (i == 20) bus.start = 1'b0;
      @(negedge clk);
    end
    for (int i = 0; i < 8; i++) @(negedge clk);
  endtask

  task automatic test_abort();
    int nb;
    int w;
    bit saw;
    nb = 0;
    w = 0;
    saw = 1'b0;
    @(negedge clk);
    bus.start   = 1'b1;
    bus.rep_cnt = 4'd1;
    @(negedge clk);
    bus.start = 1'b0;
    while (nb < 3 && w < 20) begin
      if (bus.dout_vld === 1'b1) nb++;
      if (nb < 3) @(negedge clk);
      w++;
    end
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    checks++;
    if (outs() !== 4'b0000) begin
      errors++;
      $display("FAIL abort_outs: got %b want 0000", outs());
    end
    for (int i = 0; i < 6; i++) begin
      if (bus.done !== 1'b0 || bus.dout_vld !== 1'b0) saw = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (saw) begin
      errors++;
      $display("FAIL abort_quiet: got activity want none");
    end
    build_exp(0);
    run_burst(0, -1, 0);
    checks++;
    if (first_diff() !== -1) begin
      errors++;
      $display("FAIL abort_restart: got %0d bits want %0d, diff at %0d",
               got_q.size(), exp_q.size(), first_diff());
    end
  endtask

  task automatic test_rep_change();
    build_exp(1);
    run_burst(1, 2, 15);
    checks++;
    if (first_diff() !== -1) begin
      errors++;
      $display("FAIL rep_change: got %0d bits want %0d, diff at %0d",
               got_q.size(), exp_q.size(), first_diff());
    end
    checks++;
    if (done_cnt !== 1) begin
      errors++;
      $display("FAIL rep_change_done: got %0d want 1", done_cnt);
    end
  endtask

  task automatic test_random();
    int rep;
    int chg;
    int nrep;
    for (int r = 0; r < 6; r++) begin
      rep  = $urandom_range(0, 15);
      chg  = $urandom_range(0, 20);
      nrep = $urandom_range(0, 15);
      build_exp(rep);
      run_burst(rep, chg, nrep);
      checks++;
      if (first_diff() !== -1) begin
        errors++;
        $display("FAIL rand_rep%0d: got %0d bits want %0d, diff at %0d",
                 rep, got_q.size(), exp_q.size(), first_diff());
      end
    end
  endtask

  initial begin
    bus.start   = 1'b0;
    bus.rep_cnt = 4'd0;
    test_reset();
    test_single();
    test_rep2();
    test_back_to_back();
    test_abort();
    test_rep_change();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_gen_10010.md
SEQ_GEN_10010 -- requirements
Module: seq_gen_10010

Interface
REQ-001 SHALL have parameter PAT_W, default 5, pattern width in bits.
REQ-002 SHALL have parameter PAT, default 5'b10010, serial pattern, sent MSB first.
REQ-003 SHALL have parameter OVL_KEEP, default 2, number of trailing pattern bits reused as the next frame's prefix in overlap mode.
REQ-004 SHALL have port: clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port: rst  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port: start  input  1  request a burst, sampled only in IDLE.
REQ-007 SHALL have port: rep_cnt  input  4  frames in burst minus one (0 gives 1 frame, 15 gives 16 frames).
REQ-008 SHALL have port: dout  output  1  serial pattern bit.
REQ-009 SHALL have port: dout_vld  output  1  dout carries a pattern bit this cycle.
REQ-010 SHALL have port: busy  output  1  burst in progress.
REQ-011 SHALL have port: done  output  1  one-cycle pulse after the last bit.

Function
REQ-012 SHALL register all outputs; there are no combinational input-to-output paths.
REQ-013 SHALL use states IDLE, SEND and DONE, with transitions IDLE->SEND, SEND->DONE and DONE->IDLE only.
REQ-014 SHALL, in IDLE with start=1 at edge t, latch rep_cnt, set bit index to PAT_W-1, and enter SEND, with the first bit on dout at t+1.
REQ-015 SHALL, in SEND, drive dout=PAT[idx], dout_vld=1 and busy=1, and decrement idx each cycle.
REQ-016 SHALL, at idx=0 with frames remaining, decrement the frame counter and reload idx to PAT_W-1 (overlap mode per REQ-025) with no idle gap between frames.
REQ-017 SHALL, at idx=0 with no frames remaining, enter DONE.
REQ-018 SHALL, in DONE, drive done=1, dout_vld=0, busy=0 and dout=0 for exactly one cycle, then return to IDLE.
REQ-019 SHALL, in IDLE, drive dout=0, dout_vld=0, busy=0 and done=0.
REQ-020 SHALL ignore start in SEND and DONE; a held start begins the next burst on the first IDLE cycle, giving a 2-cycle gap after the last bit.
REQ-021 SHALL keep the latched rep_cnt stable for the whole burst; changes on the rep_cnt input mid-burst have no effect.
REQ-022 SHALL emit exactly 5*(rep_cnt+1) valid bits per burst in non-overlap mode.
REQ-023 SHALL never allow the frame counter to wrap; the counter saturates at 0.

Reset
REQ-024 SHALL, while rst=0 at a clk edge (including mid-burst), go to IDLE, clear idx, the frame counter and the latched rep_cnt, and drive dout, dout_vld, busy and done to 0 from the next cycle; no done pulse is generated for an aborted burst.

Configuration
REQ-025 SHALL, with SEQ_GEN_OVERLAP_EN defined, reload idx to PAT_W-1-OVL_KEEP for frames 2..N, so consecutive frames share the trailing "10" and a burst emits 5+3*rep_cnt bits (rep_cnt=2 gives 10010010010).
REQ-026 SHALL, without SEQ_GEN_OVERLAP_EN, always reload idx to PAT_W-1, so frames are fully repeated with no shared bits.

Structure
REQ-027 SHALL place the state enum, the PAT and PAT_W defaults, and the idx and counter widths in shared package seq_pkg, which future sequence detectors reuse.
REQ-028 SHALL be implemented as a single module: one FSM plus idx and frame down-counters, with no sub-module.

Verification
REQ-029 SHALL be verified by: rst=0 for 2 cycles, then start=1 with rep_cnt=0 -> dout 1,0,0,1,0 with dout_vld=1 for 5 cycles starting at t+1, done=1 at t+6, busy=0 at t+6.
REQ-030 SHALL be verified by: rep_cnt=2 without the macro -> 15 valid bits 100101001010010 and one done pulse.
REQ-031 SHALL be verified by: rep_cnt=2 with SEQ_GEN_OVERLAP_EN -> 11 valid bits 10010010010, in which a 10010 matcher fires 3 times.
REQ-032 SHALL be verified by: start held at 1 continuously with rep_cnt=0 -> bursts of 5 bits separated by exactly 2 non-valid cycles (DONE, IDLE).
REQ-033 SHALL be verified by: rst=0 at the 3rd bit of a burst -> next cycle dout=dout_vld=busy=done=0, no done pulse; start after rst=1 gives a clean 10010.
REQ-034 SHALL be verified by: rep_cnt changed from 1 to 15 during SEND -> the burst still ends after 2 frames.
